// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a 256-byte word memory with a
// registered read port (1-cycle latency).
//   port 0 = pipeline MEM stage, port 1 = debug/loader.
//   Port 0 has fixed priority. Port 1 is forced through once it has been
//   denied STARVE_LIMIT consecutive cycles while requesting.
// Ports:
//   clk, rst                     clock, async active-high reset
//   pN_req/we/addr/wdata         request (held stable by requester until gnt)
//   pN_gnt                       combinational accept in the request cycle
//   pN_done/err/rdata            response, one cycle after grant
//   m_ra, m_wa, m_di, m_wr       memory read addr, write addr/data, write enable
//   m_do                         memory read data (registered in memory)
//
// state  | meaning
// S_IDLE | no transaction granted last cycle, no done this cycle
// S_P0   | port 0 was granted last cycle, p0_done this cycle
// S_P1   | port 1 was granted last cycle, p1_done this cycle
module mem_arbiter #(
   parameter int          STARVE_LIMIT = 4,
   parameter logic [31:0] ADDR_MAX     = 32'd252
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        p0_done,
   output logic        p1_done,
   output logic [31:0] p0_rdata,
   output logic [31:0] p1_rdata,
   output logic        p0_err,
   output logic        p1_err,
   output logic [31:0] m_ra,
   output logic [31:0] m_wa,
   output logic [31:0] m_di,
   output logic        m_wr,
   input  logic [31:0] m_do
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_P0, S_P1} own_t;

   own_t          state, next_state;
   logic [CW-1:0] starve_cnt;
   logic          rd_q, rd_d;
   logic          err_q, err_d;

   logic          sel_p1;
   logic          any_gnt;
   logic          g_we;
   logic [31:0]   g_addr;
   logic [31:0]   g_wdata;
   logic          g_legal;

   // Grant selection and request mux. Grants are masked while rst is high
   // so nothing reaches the memory or the response registers during reset.
   always_comb begin
      sel_p1  = p1_req && (!p0_req || (starve_cnt == STARVE_MAX));
      p1_gnt  = !rst && sel_p1;
      p0_gnt  = !rst && p0_req && !sel_p1;
      any_gnt = p0_gnt || p1_gnt;
      g_we    = sel_p1 ? p1_we    : p0_we;
      g_addr  = sel_p1 ? p1_addr  : p0_addr;
      g_wdata = sel_p1 ? p1_wdata : p0_wdata;
      g_legal = (g_addr[1:0] == 2'b00) && (g_addr <= ADDR_MAX);
   end

   // Memory side: only legal granted accesses drive the bus; everything
   // else presents zeros so an illegal request has no memory side effect.
   always_comb begin
      m_wr = any_gnt && g_legal && g_we;
      m_wa = m_wr ? g_addr  : 32'd0;
      m_di = m_wr ? g_wdata : 32'd0;
      m_ra = (any_gnt && g_legal && !g_we) ? g_addr : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (p1_gnt) begin
         starve_cnt <= '0;
      end else if (p1_req && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         rd_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= next_state;
         rd_q  <= rd_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      next_state = S_IDLE;
      rd_d       = 1'b0;
      err_d      = 1'b0;
      p0_done    = 1'b0;
      p1_done    = 1'b0;
      p0_err     = 1'b0;
      p1_err     = 1'b0;
      p0_rdata   = 32'd0;
      p1_rdata   = 32'd0;

      if (p0_gnt) begin
         next_state = S_P0;
      end else if (p1_gnt) begin
         next_state = S_P1;
      end
      if (any_gnt) begin
         rd_d  = g_legal && !g_we;
         err_d = !g_legal;
      end

      // m_do carries data only for a legal read; writes and illegal
      // requests return zero.
      case (state)
         S_P0: begin
            p0_done  = 1'b1;
            p0_err   = err_q;
            p0_rdata = rd_q ? m_do : 32'd0;
         end
         S_P1: begin
            p1_done  = 1'b1;
            p1_err   = err_q;
            p1_rdata = rd_q ? m_do : 32'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table applied back-to-back (one
// transaction per cycle) with a registered-read memory model, plus
// hand-written reset sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] m_ra, m_wa, m_di, m_do;
   logic        m_wr;
   logic        preload;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(4), .ADDR_MAX(32'd252)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
      .m_ra(m_ra), .m_wa(m_wa), .m_di(m_di), .m_wr(m_wr), .m_do(m_do)
   );

   // 64-word memory with registered read data
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
         mem[1] <= 32'h11111111;
         mem[2] <= 32'h22222222;
         m_do   <= 32'd0;
      end else begin
         if (m_wr) mem[m_wa[7:2]] <= m_di;
         m_do <= mem[m_ra[7:2]];
      end
   end

   typedef struct {
      logic r0, w0; logic [31:0] a0, d0;
      logic r1, w1; logic [31:0] a1, d1;
      logic g0, g1, mwr; logic [31:0] ra, wa, di;
      logic n0, e0; logic [31:0] q0;
      logic n1, e1; logic [31:0] q1;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r0, w0, input logic [31:0] a0, d0,
      input logic r1, w1, input logic [31:0] a1, d1,
      input logic g0, g1, mwr, input logic [31:0] ra, wa, di,
      input logic n0, e0, input logic [31:0] q0,
      input logic n1, e1, input logic [31:0] q1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.mwr = mwr; v.ra = ra; v.wa = wa; v.di = di;
      v.n0 = n0; v.e0 = e0; v.q0 = q0; v.n1 = n1; v.e1 = e1; v.q1 = q1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                        input logic r1, w1, input logic [31:0] a1, d1);
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
   endtask

   initial begin
      // write 0x10, read back, illegal p1 read, legal/illegal writes at top
      vq.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 1,0,1,0,32'h10,32'hDEADBEEF, 1,0,0, 0,0,0));
      vq.push_back(mk(1,0,32'h10,0, 0,0,0,0, 1,0,0,32'h10,0,0, 1,0,32'hDEADBEEF, 0,0,0));
      vq.push_back(mk(0,0,0,0, 1,0,32'h13,0, 0,1,0,0,0,0, 0,0,0, 1,1,0));
      vq.push_back(mk(1,1,32'hFC,32'hCAFEF00D, 0,0,0,0, 1,0,1,0,32'hFC,32'hCAFEF00D, 1,0,0, 0,0,0));
      vq.push_back(mk(1,1,32'h100,32'h12345678, 0,0,0,0, 1,0,0,0,0,0, 1,1,0, 0,0,0));
      // alternating reads of preloaded words
      vq.push_back(mk(1,0,32'h04,0, 0,0,0,0, 1,0,0,32'h04,0,0, 1,0,32'h11111111, 0,0,0));
      vq.push_back(mk(0,0,0,0, 1,0,32'h08,0, 0,1,0,32'h08,0,0, 0,0,0, 1,0,32'h22222222));
      vq.push_back(mk(1,0,32'h08,0, 0,0,0,0, 1,0,0,32'h08,0,0, 1,0,32'h22222222, 0,0,0));
      vq.push_back(mk(0,0,0,0, 1,0,32'h04,0, 0,1,0,32'h04,0,0, 0,0,0, 1,0,32'h11111111));
      vq.push_back(mk(0,0,0,0, 1,0,32'hFC,0, 0,1,0,32'hFC,0,0, 0,0,0, 1,0,32'hCAFEF00D));
      // idle cycle
      vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0));
      // both requesting for 10 cycles: p0 x4, p1, p0 x4, p1
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9)
            vq.push_back(mk(1,0,32'h04,0, 1,0,32'h08,0, 0,1,0,32'h08,0,0, 0,0,0, 1,0,32'h22222222));
         else
            vq.push_back(mk(1,0,32'h04,0, 1,0,32'h08,0, 1,0,0,32'h04,0,0, 1,0,32'h11111111, 0,0,0));
      end
      // p1 write then read-after-write, then misaligned p0 write
      vq.push_back(mk(0,0,0,0, 1,1,32'h20,32'h55, 0,1,1,0,32'h20,32'h55, 0,0,0, 1,0,0));
      vq.push_back(mk(0,0,0,0, 1,0,32'h20,0, 0,1,0,32'h20,0,0, 0,0,0, 1,0,32'h55));
      vq.push_back(mk(1,1,32'h02,32'hAA, 0,0,0,0, 1,0,0,0,0,0, 1,1,0, 0,0,0));

      // reset with requests pending
      rst = 1'b1; preload = 1'b1;
      drive(1,1,32'h10,32'h1, 1,1,32'h14,32'h2);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_p0_gnt", {31'd0, p0_gnt}, 0);
      chk("rst_p1_gnt", {31'd0, p1_gnt}, 0);
      chk("rst_m_wr", {31'd0, m_wr}, 0);
      chk("rst_done", {30'd0, p0_done, p1_done}, 0);
      chk("rst_err", {30'd0, p0_err, p1_err}, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
      preload = 1'b0;
      rst = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
         #3;
         chk($sformatf("v%0d_p0_gnt", i), {31'd0, p0_gnt}, {31'd0, vq[i].g0});
         chk($sformatf("v%0d_p1_gnt", i), {31'd0, p1_gnt}, {31'd0, vq[i].g1});
         chk($sformatf("v%0d_m_wr", i), {31'd0, m_wr}, {31'd0, vq[i].mwr});
         chk($sformatf("v%0d_m_ra", i), m_ra, vq[i].ra);
         chk($sformatf("v%0d_m_wa", i), m_wa, vq[i].wa);
         chk($sformatf("v%0d_m_di", i), m_di, vq[i].di);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_p0_done", i), {31'd0, p0_done}, {31'd0, vq[i].n0});
         chk($sformatf("v%0d_p1_done", i), {31'd0, p1_done}, {31'd0, vq[i].n1});
         chk($sformatf("v%0d_p0_err", i), {31'd0, p0_err}, {31'd0, vq[i].e0});
         chk($sformatf("v%0d_p1_err", i), {31'd0, p1_err}, {31'd0, vq[i].e1});
         chk($sformatf("v%0d_p0_rdata", i), p0_rdata, vq[i].q0);
         chk($sformatf("v%0d_p1_rdata", i), p1_rdata, vq[i].q1);
      end

      // async reset: clears a live done, kills a pending p1 grant
      drive(1,0,32'h04,0, 0,0,0,0);
      #3;
      @(posedge clk);
      #1;
      chk("ar_p0_done_before", {31'd0, p0_done}, 1);
      drive(0,0,0,0, 1,0,32'h04,0);
      #1;
      chk("ar_p1_gnt_before", {31'd0, p1_gnt}, 1);
      #1 rst = 1'b1;
      #1;
      chk("ar_p1_gnt_in_rst", {31'd0, p1_gnt}, 0);
      chk("ar_p0_done_cleared", {31'd0, p0_done}, 0);
      chk("ar_p0_rdata_cleared", p0_rdata, 0);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h77;
      #1;
      chk("ar_p0_gnt_in_rst", {31'd0, p0_gnt}, 0);
      chk("ar_m_wr_in_rst", {31'd0, m_wr}, 0);
      @(posedge clk);
      #1;
      chk("ar_p1_done_in_rst", {31'd0, p1_done}, 0);
      chk("ar_p1_err_in_rst", {31'd0, p1_err}, 0);
      chk("ar_p1_rdata_in_rst", p1_rdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      p0_req = 1'b0;
      #1;
      chk("rel_p1_done", {31'd0, p1_done}, 0);
      chk("rel_p1_gnt", {31'd0, p1_gnt}, 1);
      chk("rel_m_ra", m_ra, 32'h04);
      @(posedge clk);
      #1;
      chk("rel_p1_done_after", {31'd0, p1_done}, 1);
      chk("rel_p1_rdata", p1_rdata, 32'h11111111);
      chk("rel_p0_done", {31'd0, p0_done}, 0);
      chk("rel_mem_20", mem[8], 32'h55);
      drive(0,0,0,0, 0,0,0,0);
      @(posedge clk);
      #1;
      chk("end_idle_done", {30'd0, p0_done, p1_done}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
